// File: rtl/sram_2p_sync_init.sv
// One-clock 1R+1W synchronous SRAM model with masked writes, optional
// read-during-write forwarding and a zero-initialisation sweep after reset.
module sram_2p_sync_init #(
    parameter int DATA_WIDTH = 2,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = 9,
    parameter int MASK_SEGS  = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  r_en,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [MASK_SEGS-1:0]  w_mask,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  init_done
);

    localparam int                  SEG       = DATA_WIDTH / MASK_SEGS;
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [DATA_WIDTH-1:0]   bit_mask;
    logic [DATA_WIDTH-1:0]   w_old;
    logic [DATA_WIDTH-1:0]   w_merged;
    logic [DATA_WIDTH-1:0]   r_word;
    logic                    w_ok;
    logic                    r_ok;
    logic                    w_fire;
    logic                    r_fire;
    logic                    fwd;

    // NOTE: state-holding processes use <= so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) state <= INIT;
        else       state <= state_next;
    end

    // NOTE: defaults first so no path through the block leaves a latch.
    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (cnt == LAST) state_next = READY;
            READY:   state_next = READY;
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)                              cnt <= '0;
        else if (state == INIT && cnt != LAST)  cnt <= cnt + ADDR_WIDTH'(1);
    end

    assign init_done = (state == READY);

    // Out-of-range addresses exist only when DEPTH is not a power of two.
    assign w_ok   = {1'b0, w_addr} < DEPTH_EXT;
    assign r_ok   = {1'b0, r_addr} < DEPTH_EXT;
    assign w_fire = init_done && w_en && w_ok;
    assign r_fire = init_done && r_en;
    assign fwd    = (BYPASS != 0) && w_fire && (r_addr == w_addr);

    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < MASK_SEGS; i++) begin
            bit_mask[i*SEG +: SEG] = {SEG{w_mask[i]}};
        end
        w_old    = mem[w_addr];
        w_merged = (w_old & ~bit_mask) | (w_data & bit_mask);
        if (!r_ok)    r_word = '0;
        else if (fwd) r_word = w_merged;
        else          r_word = mem[r_addr];
    end

    // NOTE: the array has no reset branch; the sweep clears it one word per cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == INIT) mem[cnt]    <= '0;
            else if (w_fire)   mem[w_addr] <= w_merged;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_fire;
            if (r_fire) r_data <= r_word;
        end
    end

endmodule

// File: tb/tb_sram_2p_sync_init.sv
// Bench driving three SRAM variants (bypass, no bypass, non-power-of-two depth)
// from shared stimulus, scored against a per-variant reference model.
module tb_sram_2p_sync_init;

    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int NDUT = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          r_en;
    logic [AW-1:0] r_addr;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [1:0]    w_mask;
    logic [DW-1:0] w_data;

    logic [DW-1:0] r_data_a, r_data_b, r_data_c;
    logic          r_valid_a, r_valid_b, r_valid_c;
    logic          init_done_a, init_done_b, init_done_c;

    always #5 clock = ~clock;

    sram_2p_sync_init #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3), .MASK_SEGS(2), .BYPASS(1)) dut_a (
        .clock(clock), .reset(reset), .r_en(r_en), .r_addr(r_addr), .r_data(r_data_a),
        .r_valid(r_valid_a), .w_en(w_en), .w_addr(w_addr), .w_mask(w_mask), .w_data(w_data),
        .init_done(init_done_a));

    sram_2p_sync_init #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3), .MASK_SEGS(2), .BYPASS(0)) dut_b (
        .clock(clock), .reset(reset), .r_en(r_en), .r_addr(r_addr), .r_data(r_data_b),
        .r_valid(r_valid_b), .w_en(w_en), .w_addr(w_addr), .w_mask(w_mask), .w_data(w_data),
        .init_done(init_done_b));

    sram_2p_sync_init #(.DATA_WIDTH(8), .DEPTH(6), .ADDR_WIDTH(3), .MASK_SEGS(2), .BYPASS(1)) dut_c (
        .clock(clock), .reset(reset), .r_en(r_en), .r_addr(r_addr), .r_data(r_data_c),
        .r_valid(r_valid_c), .w_en(w_en), .w_addr(w_addr), .w_mask(w_mask), .w_data(w_data),
        .init_done(init_done_c));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model state, one slot per variant.
    int            depth_m  [NDUT] = '{8, 8, 6};
    bit            bypass_m [NDUT] = '{1'b1, 1'b0, 1'b1};
    logic [DW-1:0] mem_m    [NDUT][8];
    logic [DW-1:0] rdata_m  [NDUT];
    logic          rvalid_m [NDUT];
    int            swept_m  [NDUT];

    typedef struct {
        int            dut;
        logic          valid;
        logic [DW-1:0] data;
        logic          done;
        string         tag;
    } exp_t;

    exp_t exp_q[$];

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] din,
                                            input logic [1:0] m);
        logic [DW-1:0] r;
        r = old;
        if (m[0]) r[3:0] = din[3:0];
        if (m[1]) r[7:4] = din[7:4];
        return r;
    endfunction

    task automatic model_step(input logic rst, input logic re, input logic [AW-1:0] ra,
                              input logic we, input logic [AW-1:0] wa, input logic [1:0] wm,
                              input logic [DW-1:0] wd, input string tag);
        for (int d = 0; d < NDUT; d++) begin
            logic [DW-1:0] new_w;
            exp_t e;
            if (rst) begin
                rdata_m[d]  = '0;
                rvalid_m[d] = 1'b0;
                swept_m[d]  = 0;
            end else if (swept_m[d] < depth_m[d]) begin
                swept_m[d]++;
                rvalid_m[d] = 1'b0;
                if (swept_m[d] == depth_m[d])
                    for (int k = 0; k < 8; k++) mem_m[d][k] = '0;
            end else begin
                new_w = merge(mem_m[d][wa], wd, wm);
                rvalid_m[d] = re;
                if (re) begin
                    if (int'(ra) >= depth_m[d])                   rdata_m[d] = '0;
                    else if (bypass_m[d] && we && wa == ra)       rdata_m[d] = new_w;
                    else                                          rdata_m[d] = mem_m[d][ra];
                end
                if (we && int'(wa) < depth_m[d]) mem_m[d][wa] = new_w;
            end
            e.dut   = d;
            e.valid = rvalid_m[d];
            e.data  = rdata_m[d];
            e.done  = (swept_m[d] >= depth_m[d]);
            e.tag   = tag;
            exp_q.push_back(e);
        end
    endtask

    task automatic step(input logic rst, input logic re, input logic [AW-1:0] ra,
                        input logic we, input logic [AW-1:0] wa, input logic [1:0] wm,
                        input logic [DW-1:0] wd, input string tag);
        reset  = rst;
        r_en   = re;
        r_addr = ra;
        w_en   = we;
        w_addr = wa;
        w_mask = wm;
        w_data = wd;
        model_step(rst, re, ra, we, wa, wm, wd, tag);
        @(posedge clock);
        #1;
        while (exp_q.size() > 0) begin
            exp_t          e;
            logic          act_v;
            logic [DW-1:0] act_d;
            logic          act_done;
            e = exp_q.pop_front();
            case (e.dut)
                0:       begin act_v = r_valid_a; act_d = r_data_a; act_done = init_done_a; end
                1:       begin act_v = r_valid_b; act_d = r_data_b; act_done = init_done_b; end
                default: begin act_v = r_valid_c; act_d = r_data_c; act_done = init_done_c; end
            endcase
            check($sformatf("%s[%0d].r_valid", e.tag, e.dut), 32'(act_v), 32'(e.valid));
            check($sformatf("%s[%0d].r_data", e.tag, e.dut), 32'(act_d), 32'(e.data));
            check($sformatf("%s[%0d].init_done", e.tag, e.dut), 32'(act_done), 32'(e.done));
        end
    endtask

    task automatic idle(input string tag);
        step(1'b0, 1'b0, '0, 1'b0, '0, 2'b00, 8'h00, tag);
    endtask

    typedef struct {
        logic          re;
        logic [AW-1:0] ra;
        logic          we;
        logic [AW-1:0] wa;
        logic [1:0]    wm;
        logic [DW-1:0] wd;
        logic          ev;
        logic [DW-1:0] ed;
        string         tag;
    } vec_t;

    vec_t vecs[17];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_a;
        int first_c;

        // Expected values below are for dut_a (DEPTH 8, BYPASS 1).
        vecs[0]  = '{1'b0, 3'd0, 1'b1, 3'd3, 2'b11, 8'hAB, 1'b0, 8'h00, "wr3_ab"};
        vecs[1]  = '{1'b0, 3'd0, 1'b1, 3'd3, 2'b01, 8'h5C, 1'b0, 8'h00, "wr3_5c_lo"};
        vecs[2]  = '{1'b1, 3'd3, 1'b0, 3'd0, 2'b00, 8'h00, 1'b1, 8'hAC, "rd3_merged"};
        vecs[3]  = '{1'b0, 3'd0, 1'b1, 3'd5, 2'b11, 8'h12, 1'b0, 8'hAC, "wr5_12"};
        vecs[4]  = '{1'b1, 3'd5, 1'b1, 3'd5, 2'b10, 8'hF0, 1'b1, 8'hF2, "fwd5"};
        vecs[5]  = '{1'b1, 3'd5, 1'b0, 3'd0, 2'b00, 8'h00, 1'b1, 8'hF2, "rd5_after"};
        vecs[6]  = '{1'b1, 3'd3, 1'b0, 3'd0, 2'b00, 8'h00, 1'b1, 8'hAC, "rd3_again"};
        vecs[7]  = '{1'b0, 3'd0, 1'b0, 3'd0, 2'b00, 8'h00, 1'b0, 8'hAC, "hold1"};
        vecs[8]  = '{1'b0, 3'd0, 1'b0, 3'd0, 2'b00, 8'h00, 1'b0, 8'hAC, "hold2"};
        vecs[9]  = '{1'b0, 3'd0, 1'b0, 3'd0, 2'b00, 8'h00, 1'b0, 8'hAC, "hold3"};
        vecs[10] = '{1'b0, 3'd0, 1'b0, 3'd0, 2'b00, 8'h00, 1'b0, 8'hAC, "hold4"};
        vecs[11] = '{1'b0, 3'd0, 1'b1, 3'd7, 2'b11, 8'hFF, 1'b0, 8'hAC, "wr7_ff"};
        vecs[12] = '{1'b1, 3'd7, 1'b0, 3'd0, 2'b00, 8'h00, 1'b1, 8'hFF, "rd7"};
        vecs[13] = '{1'b1, 3'd3, 1'b1, 3'd2, 2'b11, 8'h99, 1'b1, 8'hAC, "rd3_wr2"};
        vecs[14] = '{1'b1, 3'd2, 1'b0, 3'd0, 2'b00, 8'h00, 1'b1, 8'h99, "rd2"};
        vecs[15] = '{1'b0, 3'd0, 1'b1, 3'd2, 2'b00, 8'h00, 1'b0, 8'h99, "wr2_nomask"};
        vecs[16] = '{1'b1, 3'd2, 1'b0, 3'd0, 2'b00, 8'h00, 1'b1, 8'h99, "rd2_unchanged"};

        // Reset, then the sweep with a write attempt that must be ignored.
        step(1'b1, 1'b0, '0, 1'b0, '0, 2'b00, 8'h00, "reset");
        step(1'b1, 1'b0, '0, 1'b0, '0, 2'b00, 8'h00, "reset");
        first_a = -1;
        first_c = -1;
        for (int k = 1; k <= 10; k++) begin
            if (k == 3) step(1'b0, 1'b0, '0, 1'b1, 3'd1, 2'b11, 8'h77, "init_wr");
            else        idle("init");
            if (init_done_a && first_a < 0) first_a = k;
            if (init_done_c && first_c < 0) first_c = k;
        end
        check("init_len_a", first_a, 8);
        check("init_len_c", first_c, 6);

        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, AW'(i), 1'b0, '0, 2'b00, 8'h00, "sweep_rd");

        for (int i = 0; i < 17; i++) begin
            step(1'b0, vecs[i].re, vecs[i].ra, vecs[i].we, vecs[i].wa, vecs[i].wm, vecs[i].wd,
                 vecs[i].tag);
            check({vecs[i].tag, "_tbl"}, {23'd0, r_valid_a, r_data_a}, {23'd0, vecs[i].ev, vecs[i].ed});
            if (i == 4)  check("fwd_old_b", 32'(r_data_b), 32'h12);
            if (i == 12) check("oor_rd_c", {23'd0, r_valid_c, r_data_c}, {23'd0, 1'b1, 8'h00});
        end

        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, AW'(i), 1'b0, '0, 2'b00, 8'h00, "c_keep");

        // Reset in the middle of a sweep restarts it from zero.
        step(1'b1, 1'b0, '0, 1'b0, '0, 2'b00, 8'h00, "reset2");
        for (int k = 0; k < 4; k++) idle("part_sweep");
        step(1'b1, 1'b0, '0, 1'b0, '0, 2'b00, 8'h00, "reset3");
        first_a = -1;
        first_c = -1;
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, 1'b1, 3'd3, 1'b0, '0, 2'b00, 8'h00, "resweep");
            if (init_done_a && first_a < 0) first_a = k;
            if (init_done_c && first_c < 0) first_c = k;
        end
        check("reinit_len_a", first_a, 8);
        check("reinit_len_c", first_c, 6);
        step(1'b0, 1'b1, 3'd3, 1'b0, '0, 2'b00, 8'h00, "rd_after_reinit");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_2p_sync_init.md
Name: sram_2p_sync_init

Overview:
- Parametrised one-clock, two-port (1R + 1W) synchronous SRAM behavioural model.
- Next generation of the fixed 512x2 two-port macro models used in the cache and predictor arrays.
- Adds configurable width and depth, a per-segment write mask, and read-during-write forwarding.
- Adds a hardware zero-initialisation sweep after reset and a deterministic hold of the read output.

Parameters:
- DATA_WIDTH, 2, bits per word.
- DEPTH, 512, number of words; any value >= 2, need not be a power of two.
- ADDR_WIDTH, 9, address width; ceil(log2(DEPTH)).
- MASK_SEGS, 1, write-mask segments; DATA_WIDTH must be divisible by MASK_SEGS; segment width SEG = DATA_WIDTH/MASK_SEGS.
- BYPASS, 1, 1 = a same-address same-cycle read returns the new (merged) data; 0 = it returns the old data.

Ports:
- clock  input  1  single clock for both ports; rising edge.
- reset  input  1  synchronous, active-high.
- r_en  input  1  read request.
- r_addr  input  ADDR_WIDTH  read address.
- r_data  output  DATA_WIDTH  read data.
- r_valid  output  1  r_data updated by a read accepted in the previous cycle.
- w_en  input  1  write request.
- w_addr  input  ADDR_WIDTH  write address.
- w_mask  input  MASK_SEGS  bit i enables data bits [i*SEG +: SEG].
- w_data  input  DATA_WIDTH  write data.
- init_done  output  1  high once the zero sweep completes; requests are accepted only while high.

Behaviour:
- Reset, sampled on a clock edge while reset=1:
  - r_data=0, r_valid=0, init_done=0, sweep counter=0; FSM enters INIT.
  - Array contents are not reset directly.
- FSM states: INIT and READY.
- INIT:
  - Each cycle writes 0 to array[cnt], then cnt++.
  - When cnt==DEPTH-1 is written, the FSM goes to READY and init_done=1 from the next cycle.
  - Total of exactly DEPTH cycles after reset deasserts.
- Any reset assertion in any state, including mid-sweep, restarts INIT from cnt=0.
- While INIT:
  - r_en and w_en are ignored; no array change beyond the sweep.
  - r_data holds 0; r_valid stays 0.
- READY, write:
  - w_en=1 and w_addr<DEPTH: for each segment i with w_mask[i]=1, array[w_addr] segment i takes w_data segment i. Other segments are unchanged.
  - w_mask=0 is a no-op.
- READY, read:
  - r_en=1 and r_addr<DEPTH: r_data <= array[r_addr] at the next edge (1-cycle latency); r_valid=1 in the cycle after acceptance.
- Out-of-range address (>=DEPTH, possible when DEPTH is not a power of two):
  - Write: dropped.
  - Read: accepted; r_data <= 0; r_valid=1.
- r_en=0: r_data holds its last value (no X or random data); r_valid=0.
- Same cycle, r_en=w_en=1, r_addr==w_addr:
  - BYPASS=1: r_data = masked merge of w_data over the old word (segments with w_mask=1 from w_data, others old).
  - BYPASS=0: r_data = old word.
  - The array is updated in both cases.
- Different addresses in the same cycle proceed independently.
- Back-to-back reads and writes are allowed every cycle; there is no stall and no ready back-pressure other than init_done.
- Read after write to the same address in a later cycle returns the written data.

Test Plan:
- Init sweep: DEPTH=8, DATA_WIDTH=8. Pulse reset for 2 cycles, then release.
  - init_done=0 for exactly 8 cycles, then 1.
  - Read of each address 0..7 returns 0x00 with r_valid=1 one cycle later.
- Masked write: DATA_WIDTH=8, MASK_SEGS=2. Write 0xAB mask 2'b11 to addr 3, then 0x5C mask 2'b01 to addr 3, then read addr 3.
  - r_data=0xAC.
- Forwarding: old word 0x12 at addr 5. Same cycle: write 0xF0 mask 2'b10 and read addr 5.
  - BYPASS=1: r_data=0xF2.
  - BYPASS=0: r_data=0x12.
  - Next read of addr 5 returns 0xF2 in both cases.
- Hold and gating:
  - Read addr 3 (0xAC), then r_en=0 for 4 cycles: r_data stays 0xAC and r_valid=0.
  - Write 0x77 to addr 1 during INIT: read of addr 1 after init_done returns 0x00.
- Reset mid-sweep: DEPTH=8. Assert reset at cnt=4.
  - init_done rises exactly 8 cycles after reset release.
  - r_data=0 throughout.
- Out-of-range: DEPTH=6, ADDR_WIDTH=3.
  - Write 0xFF to addr 7: array unchanged.
  - Read addr 7: r_data=0x00, r_valid=1.
  - Addr 0..5 still hold their prior values.
